// File: rtl/warmboot_ctrl.sv
// Warmboot request controller: synchronises BOOT/SLOT from the switch matrix, qualifies a stable
// request and runs one req/ack handshake with timeout and cooldown.
module warmboot_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned COOLDOWN    = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BOOT,
  input  logic [3:0] SLOT,
  input  logic       enable_i,
  output logic       boot_req_o,
  output logic [3:0] boot_slot_o,
  input  logic       boot_ack_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned CntW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT);
  localparam int unsigned CoolW = $clog2(COOLDOWN + 1);

  localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [CoolW-1:0] CoolLast = CoolW'(COOLDOWN - 1);

  typedef enum logic [1:0] {StIdle, StQual, StReq, StCool} state_e;

  state_e                          state_q, state_d;
  logic [SYNC_STAGES-1:0]          boot_sync_q, boot_sync_d;
  logic [SYNC_STAGES-1:0][3:0]     slot_sync_q, slot_sync_d;
  logic [SYNC_STAGES-1:0]          fill_q, fill_d;
  logic                            armed_q, armed_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [3:0]                      slot_q, slot_d;
  logic [TmoW-1:0]                 tmo_q, tmo_d;
  logic [CoolW-1:0]                cool_q, cool_d;
  logic                            req_q, req_d;
  logic                            err_q, err_d;
  logic                            busy_q, busy_d;

  logic       boot_s;
  logic [3:0] slot_s;
  logic       sync_ok;

  assign boot_s  = boot_sync_q[SYNC_STAGES-1];
  assign slot_s  = slot_sync_q[SYNC_STAGES-1];
  // The chain holds reset zeros until refilled; those must not count as BOOT seen low.
  assign sync_ok = fill_q[SYNC_STAGES-1];

  always_comb begin
    boot_sync_d = {boot_sync_q[SYNC_STAGES-2:0], BOOT};
    slot_sync_d = {slot_sync_q[SYNC_STAGES-2:0], SLOT};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    state_d     = state_q;
    armed_d     = armed_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    tmo_d       = tmo_q;
    cool_d      = cool_q;
    req_d       = req_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (sync_ok && !boot_s) begin
          armed_d = 1'b1;
        end
        if (enable_i && armed_q && boot_s) begin
          state_d = StQual;
          cnt_d   = CntW'(1);
          slot_d  = slot_s;
        end
      end
      StQual: begin
        if (!boot_s || !enable_i) begin
          state_d = StIdle;
        end else if (slot_s != slot_q) begin
          cnt_d  = CntW'(1);
          slot_d = slot_s;
        end else if (cnt_q >= HoldLast) begin
          state_d = StReq;
          req_d   = 1'b1;
          armed_d = 1'b0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReq: begin
        if (boot_ack_i) begin
          state_d = StCool;
          req_d   = 1'b0;
          err_d   = 1'b0;
          cool_d  = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StCool;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cool_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCool: begin
        if (cool_q == CoolLast) begin
          state_d = StIdle;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      boot_sync_q <= '0;
      slot_sync_q <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      slot_q      <= '0;
      tmo_q       <= '0;
      cool_q      <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_sync_q <= boot_sync_d;
      slot_sync_q <= slot_sync_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      tmo_q       <= tmo_d;
      cool_q      <= cool_d;
      req_q       <= req_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign boot_req_o  = req_q;
  assign boot_slot_o = slot_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Bench for warmboot_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_warmboot_ctrl;

  localparam int SyncStages = 2;
  localparam int HoldCycles = 4;
  localparam int Timeout    = 1024;
  localparam int Cooldown   = 16;

  localparam int MIdle = 0;
  localparam int MQual = 1;
  localparam int MReq  = 2;
  localparam int MCool = 3;

  logic       CLK;
  logic       RESET;
  logic       BOOT;
  logic [3:0] SLOT;
  logic       enable_i;
  logic       boot_req_o;
  logic [3:0] boot_slot_o;
  logic       boot_ack_i;
  logic       busy_o;
  logic       err_o;

  warmboot_ctrl #(
    .SYNC_STAGES(SyncStages),
    .HOLD_CYCLES(HoldCycles),
    .TIMEOUT    (Timeout),
    .COOLDOWN   (Cooldown)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BOOT       (BOOT),
    .SLOT       (SLOT),
    .enable_i   (enable_i),
    .boot_req_o (boot_req_o),
    .boot_slot_o(boot_slot_o),
    .boot_ack_i (boot_ack_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit seen_req = 0;

  // Model: BOOT/SLOT history queues stand in for the synchroniser delay; -1 marks
  // post-reset history that carries no information about BOOT.
  int         bq[$];
  int         sq[$];
  int         m_mode;
  bit         m_armed;
  int         m_run;
  int         m_age;
  int         m_left;
  logic [3:0] m_slot;
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    bq.delete();
    sq.delete();
    for (int i = 0; i < SyncStages; i++) begin
      bq.push_back(-1);
      sq.push_back(0);
    end
    m_mode  = MIdle;
    m_armed = 0;
    m_run   = 0;
    m_age   = 0;
    m_left  = 0;
    m_slot  = 4'h0;
    m_err   = 0;
  endfunction

  function automatic bit m_req();
    return m_mode == MReq;
  endfunction

  function automatic void model_step(input bit b, input logic [3:0] s, input bit en,
                                     input bit ack, input bit rst);
    int         bv;
    logic [3:0] ss;
    if (rst) begin
      model_reset();
      return;
    end
    bv = bq.pop_front();
    ss = 4'(sq.pop_front());
    bq.push_back(int'(b));
    sq.push_back(int'(s));
    case (m_mode)
      MIdle: begin
        if (bv == 0) m_armed = 1;
        else if (bv == 1 && en && m_armed) begin
          m_mode = MQual;
          m_run  = 1;
          m_slot = ss;
        end
      end
      MQual: begin
        if (bv != 1 || !en) m_mode = MIdle;
        else if (ss != m_slot) begin
          m_run  = 1;
          m_slot = ss;
        end else begin
          m_run++;
          if (m_run >= HoldCycles) begin
            m_mode  = MReq;
            m_armed = 0;
            m_age   = 0;
          end
        end
      end
      MReq: begin
        if (ack) begin
          m_mode = MCool;
          m_left = Cooldown;
          m_err  = 0;
        end else begin
          m_age++;
          if (m_age == Timeout) begin
            m_mode = MCool;
            m_left = Cooldown;
            m_err  = 1;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = MIdle;
      end
    endcase
  endfunction

  task automatic cycle(input bit b, input logic [3:0] s, input bit en, input bit ack,
                       input bit rst);
    BOOT       = b;
    SLOT       = s;
    enable_i   = en;
    boot_ack_i = ack;
    RESET      = rst;
    @(posedge CLK);
    model_step(b, s, en, ack, rst);
    cyc++;
    #1;
    if (boot_req_o) seen_req = 1;
    check("req", 32'(boot_req_o), 32'(m_req()));
    check("busy", 32'(busy_o), 32'(m_mode != MIdle));
    check("err", 32'(err_o), 32'(m_err));
    if (m_req()) check("slot", 32'(boot_slot_o), 32'(m_slot));
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_timeout(input logic [3:0] s);
    int hi = 0;
    for (int i = 0; i < 1060; i++) begin
      cycle(i < 10, s, 1'b1, 1'b0, 1'b0);
      if (boot_req_o) hi++;
    end
    check("t5_req_len", 32'(hi), 32'(Timeout));
    check("t5_err_set", 32'(err_o), 32'd1);
    check("t5_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    bit         rb;
    logic [3:0] rs;
    model_reset();

    // Reset, then BOOT low so the controller arms.
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    check("rst_req", 32'(boot_req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    idle_low(3);

    // T1: basic handshake; ack while req high at edge 8.
    for (int i = 0; i < 31; i++) begin
      cycle(i < 10, 4'hA, 1'b1, i == 8, 1'b0);
      if (i == 4) check("t1_req_e4", 32'(boot_req_o), 32'd0);
      if (i == 5) begin
        check("t1_req_e5", 32'(boot_req_o), 32'd1);
        check("t1_slot", 32'(boot_slot_o), 32'hA);
      end
      if (i == 7) check("t1_req_e7", 32'(boot_req_o), 32'd1);
      if (i == 8) begin
        check("t1_req_drop", 32'(boot_req_o), 32'd0);
        check("t1_busy_cool", 32'(busy_o), 32'd1);
      end
      if (i == 23) check("t1_busy_e23", 32'(busy_o), 32'd1);
      if (i == 24) check("t1_busy_e24", 32'(busy_o), 32'd0);
    end

    // T2: three-cycle glitch must not qualify.
    seen_req = 0;
    for (int i = 0; i < 12; i++) cycle(i < 3, 4'h6, 1'b1, 1'b0, 1'b0);
    check("t2_noreq", 32'(seen_req), 32'd0);
    check("t2_idle", 32'(busy_o), 32'd0);

    // T3: BOOT stuck high through reset; only fires after it drops.
    cycle(1'b1, 4'h7, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 4'h7, 1'b1, 1'b0, 1'b1);
    seen_req = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    check("t3_stuck_noreq", 32'(seen_req), 32'd0);
    cycle(1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
    seen_req = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'h7, 1'b1, m_req(), 1'b0);
    check("t3_refire", 32'(seen_req), 32'd1);
    idle_low(20);

    // T4: slot changes 3 -> 5 during the second qualify cycle.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, (i < 2) ? 4'h3 : 4'h5, 1'b1, i == 8, 1'b0);
      if (i == 6) check("t4_req_e6", 32'(boot_req_o), 32'd0);
      if (i == 7) begin
        check("t4_req_e7", 32'(boot_req_o), 32'd1);
        check("t4_slot", 32'(boot_slot_o), 32'h5);
      end
    end
    idle_low(20);

    // T5: timeout, then an acked request clears the sticky error.
    do_timeout(4'h9);
    for (int i = 0; i < 30; i++) begin
      cycle(i < 10, 4'h2, 1'b1, i == 7, 1'b0);
      if (i == 6) check("t5_err_sticky", 32'(err_o), 32'd1);
      if (i == 7) check("t5_err_clr", 32'(err_o), 32'd0);
    end
    do_timeout(4'h4);

    // T6: reset pulse mid-REQ with BOOT held high.
    seen_req = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 4'hC, 1'b1, 1'b0, i == 7);
      if (i == 6) begin
        check("t6_req_pre", 32'(boot_req_o), 32'd1);
        check("t6_err_pre", 32'(err_o), 32'd1);
      end
      if (i == 7) begin
        check("t6_req", 32'(boot_req_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_err", 32'(err_o), 32'd0);
        seen_req = 0;
      end
    end
    check("t6_noretrig", 32'(seen_req), 32'd0);
    idle_low(4);

    // Random traffic.
    rb = 0;
    rs = 4'h0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) rb = ~rb;
      if ($urandom_range(15) == 0) rs = 4'($urandom);
      cycle(rb, rs, $urandom_range(31) != 0,
            m_req() ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0),
            $urandom_range(499) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
